// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory that answers CPU load/store
// requests after a fixed number of wait states.
//
// Handshake: a request (memwrite|memread) is taken on the rising edge where
// the responder is IDLE. Request inputs are ignored until the responder is
// IDLE again. The response is a one-cycle ready pulse WAIT+1 cycles after
// the accepting edge. readdata is meaningful while ready=1 and holds the
// last load result afterwards. There is no back-pressure from the CPU side.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err,
    output logic [15:0] wr_count,
    output logic [1:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            re_q, re_d;
    logic            mis_q, mis_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [15:0]     wrc_q, wrc_d;

    logic [31:0]     mem_q [DEPTH];

    // Effective operation: taken straight from the inputs when accepting in
    // IDLE (needed when WAIT=0 jumps directly to RESP), else from the latch.
    logic            op_we;
    logic            op_re;
    logic            op_mis;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_wdata;
    logic            req;
    logic            enter_resp;
    logic            commit_wr;

    // Address bits above the word index are deliberately ignored (wrap).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^dataadr[31:AW+2];

    assign req = memwrite | memread;

    // Select the operation that the next RESP entry will act on.
    always_comb begin
        op_we    = we_q;
        op_re    = re_q;
        op_mis   = mis_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_we    = memwrite;
            op_re    = memread;
            op_mis   = (dataadr[1:0] != 2'b00);
            op_idx   = dataadr[AW+1:2];
            op_wdata = writedata;
        end
    end

    // A store is committed only on the edge that enters RESP, and never
    // while reset is held (the memory itself has no reset).
    assign enter_resp = (state_d == RESP) && !reset;
    assign commit_wr  = enter_resp && op_we && !op_mis;

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> BUSY (WAIT cycles) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ready     = (state_q == RESP);
        state_dbg = state_q;
    end

    // Next values of the request latch, load data, error flag and counter.
    always_comb begin
        we_d    = we_q;
        re_d    = re_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wrc_d   = wrc_q;
        if (state_q == IDLE && req) begin
            we_d    = memwrite;
            re_d    = memread;
            mis_d   = (dataadr[1:0] != 2'b00);
            idx_d   = dataadr[AW+1:2];
            wdata_d = writedata;
        end
        if (enter_resp) begin
            // Loads (including a combined store+load) sample the word
            // before this edge's write, giving read-before-write.
            if (op_re) begin
                rdata_d = mem_q[op_idx];
            end
            if (op_mis) begin
                err_d = 1'b1;
            end
        end
        if (commit_wr && wrc_q != 16'hFFFF) begin
            wrc_d = wrc_q + 16'd1;
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wrc_q   <= 16'd0;
        end else begin
            we_q    <= we_d;
            re_q    <= re_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wrc_q   <= wrc_d;
        end
    end

    // Storage array: synchronous write, contents not reset.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem_q[op_idx] <= op_wdata;
        end
    end

    assign readdata = rdata_q;
    assign err      = err_q;
    assign wr_count = wrc_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // index 0: WAIT=2 instance, index 1: WAIT=0 instance
    logic        mw [2];
    logic        mr [2];
    logic [31:0] adr [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic        rdy [2];
    logic        er [2];
    logic [15:0] wc [2];
    logic [1:0]  st [2];

    dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .memwrite(mw[0]), .memread(mr[0]),
        .dataadr(adr[0]), .writedata(wd[0]), .readdata(rd[0]), .ready(rdy[0]),
        .err(er[0]), .wr_count(wc[0]), .state_dbg(st[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .memwrite(mw[1]), .memread(mr[1]),
        .dataadr(adr[1]), .writedata(wd[1]), .readdata(rd[1]), .ready(rdy[1]),
        .err(er[1]), .wr_count(wc[1]), .state_dbg(st[1])
    );

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] last_rd [2];
    int          wrc_m [2];
    bit          err_m [2];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = 32'd0;
            wrc_m[s]   = 0;
            err_m[s]   = 1'b0;
        end
    endtask

    // Update the reference model for an accepted request and push the
    // readdata value expected with its ready pulse.
    task automatic model_drive(input int s, input bit we, input bit re,
                               input logic [31:0] a, input logic [31:0] d);
        int idx;
        bit mis;
        idx = int'((a >> 2) % DEPTH);
        mis = (a % 4) != 0;
        if (re) last_rd[s] = mem_m[s][idx];
        exp_q.push_back(last_rd[s]);
        if (mis) err_m[s] = 1'b1;
        else if (we) begin
            mem_m[s][idx] = d;
            if (wrc_m[s] < 65535) wrc_m[s]++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic access(input int s, input bit we, input bit re,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        int lat;
        logic [31:0] x;
        lat = (s == 0) ? 3 : 1;
        @(negedge clk);
        mw[s] = we; mr[s] = re; adr[s] = a; wd[s] = d;
        model_drive(s, we, re, a, d);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        // garbage on the address/data lines must not disturb the latched request
        mw[s] = 1'b0; mr[s] = 1'b0; adr[s] = $urandom; wd[s] = $urandom;
        while (rdy[s] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        x = exp_q.pop_front();
        chk("readdata", rd[s], x);
        chk("wr_count", {16'd0, wc[s]}, wrc_m[s]);
        chk("err", {31'd0, er[s]}, {31'd0, err_m[s]});
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, rdy[s]}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rdat;
        for (int s = 0; s < 2; s++) begin
            mw[s] = 1'b0; mr[s] = 1'b0; adr[s] = 32'd0; wd[s] = 32'd0;
        end
        model_reset();
        reset = 1'b1;
        #21;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", {31'd0, rdy[s]}, 32'd0);
            chk("rst_err", {31'd0, er[s]}, 32'd0);
            chk("rst_wr_count", {16'd0, wc[s]}, 32'd0);
            chk("rst_readdata", rd[s], 32'd0);
            chk("rst_state", {30'd0, st[s]}, 32'd0);
        end
        #1 reset = 1'b0;   // released at 22 ns

        // basic store then load, WAIT=2
        access(0, 1, 0, 32'd84, 32'd7);
        access(0, 0, 1, 32'd84, 32'd0);
        // address wrap
        access(0, 1, 0, 32'd84 + 4 * DEPTH, 32'd5);
        access(0, 0, 1, 32'd84, 32'd0);
        // misaligned store: suppressed, err sticky, word 84 intact
        access(0, 1, 0, 32'd86, 32'd9);
        access(0, 0, 1, 32'd84, 32'd0);
        // combined store+load returns the old word
        access(0, 1, 0, 32'd88, 32'd3);
        access(0, 1, 1, 32'd88, 32'd4);
        access(0, 0, 1, 32'd88, 32'd0);
        // misaligned load returns the aligned word
        access(0, 0, 1, 32'd85, 32'd0);

        // WAIT=0: store then a held load answered every second cycle
        access(1, 1, 0, 32'd80, 32'hDEADBEEF);
        @(negedge clk);
        mr[1] = 1'b1; adr[1] = 32'd80;
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) model_drive(1, 0, 1, 32'd80, 32'd0);
            @(negedge clk);
            if (n % 2 == 0) begin
                chk("hold_ready_hi", {31'd0, rdy[1]}, 32'd1);
                e = exp_q.pop_front();
                chk("hold_readdata", rd[1], e);
            end else begin
                chk("hold_ready_lo", {31'd0, rdy[1]}, 32'd0);
            end
        end
        mr[1] = 1'b0;

        // random aligned store/load pairs on both instances
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                ra   = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3) * 4 * DEPTH);
                rdat = $urandom;
                access(s, 1, 0, ra, rdat);
                access(s, 0, 1, ra + 32'($urandom_range(0, 1) * 4 * DEPTH), 32'd0);
            end
        end

        // reset during BUSY drops the pending store
        access(0, 1, 0, 32'd92, 32'h11);
        @(negedge clk);
        mw[0] = 1'b1; adr[0] = 32'd92; wd[0] = 32'd1;
        @(posedge clk);
        @(negedge clk);
        mw[0] = 1'b0;
        chk("abort_in_busy", {30'd0, st[0]}, 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_state", {30'd0, st[0]}, 32'd0);
        chk("async_rst_ready", {31'd0, rdy[0]}, 32'd0);
        chk("async_rst_wr_count", {16'd0, wc[0]}, 32'd0);
        chk("async_rst_readdata", rd[0], 32'd0);
        chk("async_rst_err", {31'd0, er[0]}, 32'd0);
        chk("async_rst_wr_count_w0", {16'd0, wc[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("no_ready_after_abort", {31'd0, rdy[0]}, 32'd0);
        end
        access(0, 0, 1, 32'd92, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
